// File: rtl/sap_cpu_core_if.sv
// Memory bus between sap_cpu_core (master) and the program/data RAM (slave).
// Read data is returned the cycle after o_mem_rd; a write lands at the end of the o_mem_we cycle.
interface sap_cpu_core_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_rd;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              o_mem_we;
    logic [DATA_W-1:0] o_mem_wdata;

    modport master (
        output o_mem_addr,
        output o_mem_rd,
        input  i_mem_rdata,
        output o_mem_we,
        output o_mem_wdata
    );

    modport slave (
        input  o_mem_addr,
        input  o_mem_rd,
        output i_mem_rdata,
        input  o_mem_we,
        input  o_mem_wdata
    );
endinterface

// File: rtl/sap_cpu_core.sv
// Multi-cycle accumulator CPU (T0 fetch, T1 decode, T2 execute, T3 memory operand).
// Optional SAP_SINGLE_STEP_EN adds i_step: the core waits in T0 until i_step is sampled high.
module sap_cpu_core #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
`ifdef SAP_SINGLE_STEP_EN
    input  logic              i_step,
`endif
    sap_cpu_core_if.master    mem,
    output logic [DATA_W-1:0] o_out,
    output logic              o_out_valid,
    output logic              o_halted,
    output logic              o_flag_c,
    output logic              o_flag_z,
    output logic              o_illegal
);
    typedef enum logic [1:0] {T0, T1, T2, T3} stage_e;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_LDA = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_STA = 4'b0100,
        OP_LDI = 4'b0101,
        OP_JMP = 4'b0110,
        OP_JC  = 4'b0111,
        OP_JZ  = 4'b1000,
        OP_OUT = 4'b1110,
        OP_HLT = 4'b1111
    } opcode_e;

    stage_e            stage_q, stage_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;

    logic              step_ok;
    opcode_e           opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W:0]   sum;

`ifdef SAP_SINGLE_STEP_EN
    assign step_ok = i_step;
`else
    assign step_ok = 1'b1;
`endif

    assign opcode  = opcode_e'(ir_q[DATA_W-1 -: 4]);
    assign operand = ir_q[ADDR_W-1:0];
    assign sum     = {1'b0, a_q} + {1'b0, mem.i_mem_rdata};

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            stage_q     <= T0;
            pc_q        <= '0;
            a_q         <= '0;
            ir_q        <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            stage_q     <= stage_d;
            pc_q        <= pc_d;
            a_q         <= a_d;
            ir_q        <= ir_d;
            c_q         <= c_d;
            z_q         <= z_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    always_comb begin
        stage_d         = stage_q;
        pc_d            = pc_q;
        a_d             = a_q;
        ir_d            = ir_q;
        c_d             = c_q;
        z_d             = z_q;
        out_d           = out_q;
        out_valid_d     = 1'b0;
        halted_d        = halted_q;
        illegal_d       = 1'b0;
        mem.o_mem_addr  = pc_q;
        mem.o_mem_rd    = 1'b0;
        mem.o_mem_we    = 1'b0;

        case (stage_q)
            T0: begin
                // A halted core parks here with no bus activity.
                if (!halted_q && step_ok) begin
                    mem.o_mem_rd = 1'b1;
                    stage_d      = T1;
                end
            end
            T1: begin
                ir_d    = mem.i_mem_rdata;
                pc_d    = pc_q + ADDR_W'(1);
                stage_d = T2;
            end
            T2: begin
                stage_d = T0;
                case (opcode)
                    OP_NOP: ;
                    OP_LDI: a_d = {{(DATA_W-ADDR_W){1'b0}}, operand};
                    OP_JMP: pc_d = operand;
                    OP_JC:  if (c_q) pc_d = operand;
                    OP_JZ:  if (z_q) pc_d = operand;
                    OP_OUT: begin
                        out_d       = a_q;
                        out_valid_d = 1'b1;
                    end
                    OP_STA: begin
                        mem.o_mem_addr = operand;
                        mem.o_mem_we   = 1'b1;
                    end
                    OP_LDA, OP_ADD, OP_SUB: begin
                        mem.o_mem_addr = operand;
                        mem.o_mem_rd   = 1'b1;
                        stage_d        = T3;
                    end
                    OP_HLT: halted_d = 1'b1;
                    default: illegal_d = 1'b1;
                endcase
            end
            T3: begin
                stage_d = T0;
                case (opcode)
                    OP_LDA: a_d = mem.i_mem_rdata;
                    OP_ADD: begin
                        {c_d, a_d} = sum;
                        z_d        = (sum[DATA_W-1:0] == '0);
                    end
                    OP_SUB: begin
                        a_d = a_q - mem.i_mem_rdata;
                        c_d = (a_q >= mem.i_mem_rdata);
                        z_d = (a_q == mem.i_mem_rdata);
                    end
                    default: ;
                endcase
            end
            default: stage_d = T0;
        endcase
    end

    assign mem.o_mem_wdata = a_q;
    assign o_out           = out_q;
    assign o_out_valid     = out_valid_q;
    assign o_halted        = halted_q;
    assign o_flag_c        = c_q;
    assign o_flag_z        = z_q;
    assign o_illegal       = illegal_q;
endmodule

// File: tb/tb_sap_cpu_core.sv
// Scoreboarded bench for sap_cpu_core: small programs in a behavioural RAM,
// expected OUT values and memory writes queued up front and checked as the core produces them.
module tb_sap_cpu_core;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [7:0] o_out;
    logic       o_out_valid, o_halted, o_flag_c, o_flag_z, o_illegal;
`ifdef SAP_SINGLE_STEP_EN
    logic       i_step = 1'b1;
`endif

    sap_cpu_core_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
`ifdef SAP_SINGLE_STEP_EN
        .i_step      (i_step),
`endif
        .mem         (bus.master),
        .o_out       (o_out),
        .o_out_valid (o_out_valid),
        .o_halted    (o_halted),
        .o_flag_c    (o_flag_c),
        .o_flag_z    (o_flag_z),
        .o_illegal   (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0]  ram [16];
    logic [7:0]  rdata_q = '0;
    assign bus.i_mem_rdata = rdata_q;

    always @(posedge i_clk) begin
        if (bus.o_mem_rd) rdata_q <= ram[bus.o_mem_addr];
        if (bus.o_mem_we) ram[bus.o_mem_addr] <= bus.o_mem_wdata;
    end

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    logic [7:0]  exp_out [$];
    logic [11:0] exp_wr  [$];
    int unsigned rd_cnt = 0, we_cnt = 0, illegal_cnt = 0;

    always @(negedge i_clk) begin
        if (i_rst) begin
            if (bus.o_mem_rd) rd_cnt++;
            if (o_illegal)    illegal_cnt++;
            if (o_out_valid) begin
                if (exp_out.size() == 0) check("out_unexpected", {24'd0, o_out}, 32'hDEAD);
                else                     check("out_value", {24'd0, o_out}, {24'd0, exp_out.pop_front()});
            end
            if (bus.o_mem_we) begin
                we_cnt++;
                if (exp_wr.size() == 0) check("wr_unexpected", {20'd0, bus.o_mem_addr, bus.o_mem_wdata}, 32'hDEAD);
                else                    check("wr_addr_data", {20'd0, bus.o_mem_addr, bus.o_mem_wdata}, {20'd0, exp_wr.pop_front()});
            end
        end
    end

    task automatic clear_ram();
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        rd_cnt = 0; we_cnt = 0; illegal_cnt = 0;
        i_rst = 1'b1;
    endtask

    task automatic run_to_halt(input string tag);
        int unsigned n = 0;
        while (!o_halted && n < 300) begin
            @(negedge i_clk);
            n++;
        end
        check({tag, "_halt_reached"}, {31'd0, o_halted}, 32'd1);
        check({tag, "_outq_drained"}, exp_out.size(), 32'd0);
        check({tag, "_wrq_drained"}, exp_wr.size(), 32'd0);
    endtask

    initial begin
        clear_ram();
        // Reset state
        @(negedge i_clk);
        check("rst_addr", {28'd0, bus.o_mem_addr}, 32'd0);
        check("rst_rd", {31'd0, bus.o_mem_rd}, 32'd1);
        check("rst_we", {31'd0, bus.o_mem_we}, 32'd0);
        check("rst_out", {24'd0, o_out}, 32'd0);
        check("rst_flags_halt", {29'd0, o_flag_c, o_flag_z, o_halted}, 32'd0);

        // LDI 7; ADD 14; OUT; HLT with mem[14]=5 -> 12, halts after 13 cycles
        ram[0] = 8'h57; ram[1] = 8'h2E; ram[2] = 8'hE0; ram[3] = 8'hF0; ram[14] = 8'h05;
        exp_out.push_back(8'd12);
        do_reset();
        repeat (12) @(posedge i_clk);
        #1 check("t1_not_halted_c12", {31'd0, o_halted}, 32'd0);
        @(posedge i_clk);
        #1 check("t1_halted_c13", {31'd0, o_halted}, 32'd1);
        run_to_halt("t1");
        check("t1_flags", {30'd0, o_flag_c, o_flag_z}, 32'd0);
        rd_cnt = 0;
        repeat (10) @(negedge i_clk);
        check("t1_no_rd_halted", rd_cnt, 32'd0);
        check("t1_no_we_halted", we_cnt, 32'd0);

        // LDA 13 (0xC8); ADD 14 (0x64); OUT -> 0x2C with carry
        clear_ram();
        ram[0] = 8'h1D; ram[1] = 8'h2E; ram[2] = 8'hE0; ram[3] = 8'hF0;
        ram[13] = 8'hC8; ram[14] = 8'h64;
        exp_out.push_back(8'h2C);
        do_reset();
        run_to_halt("t2");
        check("t2_flags", {30'd0, o_flag_c, o_flag_z}, 32'b10);

        // LDI 5; SUB 14; JZ 8 taken (mem[14]=5) and not taken (mem[14]=6)
        for (int pass = 0; pass < 2; pass++) begin
            clear_ram();
            ram[0] = 8'h55; ram[1] = 8'h3E; ram[2] = 8'h88;
            ram[3] = 8'hE0; ram[4] = 8'hF0;
            ram[8] = 8'hE0; ram[9] = 8'h58; ram[10] = 8'hE0; ram[11] = 8'hF0;
            if (pass == 0) begin
                ram[14] = 8'h05;
                exp_out.push_back(8'h00);
                exp_out.push_back(8'h08);
            end else begin
                ram[14] = 8'h06;
                exp_out.push_back(8'hFF);
            end
            do_reset();
            run_to_halt(pass == 0 ? "t3z" : "t3nz");
            if (pass == 0) begin
                check("t3z_flags", {30'd0, o_flag_c, o_flag_z}, 32'b11);
                check("t3z_a", {24'd0, bus.o_mem_wdata}, 32'h08);
            end else begin
                check("t3nz_flags", {30'd0, o_flag_c, o_flag_z}, 32'b00);
                check("t3nz_a", {24'd0, bus.o_mem_wdata}, 32'hFF);
            end
        end

        // LDI 9; STA 15; LDI 0; LDA 15; OUT; HLT
        clear_ram();
        ram[0] = 8'h59; ram[1] = 8'h4F; ram[2] = 8'h50; ram[3] = 8'h1F; ram[4] = 8'hE0; ram[5] = 8'hF0;
        exp_wr.push_back({4'd15, 8'd9});
        exp_out.push_back(8'd9);
        do_reset();
        run_to_halt("t4");
        check("t4_we_cycles", we_cnt, 32'd1);
        check("t4_ram15", {24'd0, ram[15]}, 32'd9);

        // pc wrap through a NOP at 15, then an undefined opcode 1010
        clear_ram();
        ram[0] = 8'h74; ram[1] = 8'h1D; ram[2] = 8'h2D; ram[3] = 8'h6F; ram[15] = 8'h00;
        ram[4] = 8'hE0; ram[5] = 8'hA0; ram[6] = 8'h52; ram[7] = 8'hE0; ram[8] = 8'hF0;
        ram[13] = 8'hFF;
        exp_out.push_back(8'hFE);
        exp_out.push_back(8'h02);
        do_reset();
        run_to_halt("t5");
        check("t5_illegal_pulses", illegal_cnt, 32'd1);

        // Reset asserted during T3 of the second ADD (cycle 15)
        clear_ram();
        ram[0] = 8'h1D; ram[1] = 8'h2E; ram[2] = 8'hE0; ram[3] = 8'h2E; ram[4] = 8'hF0;
        ram[13] = 8'hC8; ram[14] = 8'h64;
        exp_out.push_back(8'h2C);
        do_reset();
        repeat (14) @(posedge i_clk);
        #2 i_rst = 1'b0;
        #1;
        check("t6_rst_a", {24'd0, bus.o_mem_wdata}, 32'd0);
        check("t6_rst_flags", {30'd0, o_flag_c, o_flag_z}, 32'd0);
        check("t6_rst_out", {24'd0, o_out}, 32'd0);
        check("t6_rst_pc", {28'd0, bus.o_mem_addr}, 32'd0);
        check("t6_rst_we", {31'd0, bus.o_mem_we}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("t6_first_fetch_addr", {28'd0, bus.o_mem_addr}, 32'd0);
        check("t6_first_fetch_rd", {31'd0, bus.o_mem_rd}, 32'd1);
        exp_out.push_back(8'h2C);
        run_to_halt("t6");
        check("t6_final_a", {24'd0, bus.o_mem_wdata}, 32'h90);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
